sram_serial_master: RTL and testbench
=====================================

Name: sram_serial_master

Overview:
- Initiator side of the CPLD SRAM access interface.
- Takes parallel read/write commands and serialises the 21-bit SRAM address onto the serial address line (avr_si / avr_clk), MSB first, into the CPLD address shift register.
- Then runs one strobed SRAM byte access over the shared 8-bit data bus with avr_ce / avr_oe / avr_we.
- Replaces the AVR firmware bit-banging when a host-side FPGA or bench model drives the cartridge.

Parameters:
- ADDR_W, 21, address width; number of bits shifted per command.
- HALF_DIV, 2, clk cycles per avr_clk half period (>=1).
- ACCESS_CYC, 3, clk cycles the oe/we strobe is held low (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  SRAM address.
- cmd_wdata  input  8  write byte.
- rsp_valid  output  1  one-cycle pulse at command completion (reads and writes).
- rsp_rdata  output  8  read byte; valid with rsp_valid, holds value until the next read completes.
- avr_si  output  1  serial address bit.
- avr_clk  output  1  shift clock; the CPLD shifts on its rising edge.
- avr_ce  output  1  SRAM chip enable, active low.
- avr_oe  output  1  SRAM output enable, active low.
- avr_we  output  1  SRAM write enable, active low.
- avr_data_out  output  8  data driven to the bus.
- avr_data_oe  output  1  tri-state enable for avr_data_out.
- avr_data_in  input  8  bus read-back.

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0.
  - avr_si=0, avr_clk=0.
  - avr_ce=1, avr_oe=1, avr_we=1.
  - avr_data_out=0, avr_data_oe=0.
  - Bit counter and divider = 0.
- Reset mid-operation: aborts immediately; all strobes deassert on the next edge; the command is lost and no rsp_valid is issued.
- States: IDLE, SHIFT_LO, SHIFT_HI, SETUP, ACCESS, HOLD, DONE.
- IDLE → SHIFT_LO on accept. On accept, latch addr/we/wdata and load the bit counter with ADDR_W-1.
- SHIFT_LO:
  - avr_clk=0; avr_si = latched addr[counter].
  - Stays HALF_DIV cycles, then → SHIFT_HI.
- SHIFT_HI:
  - avr_clk=1; avr_si stable.
  - Stays HALF_DIV cycles.
  - If counter==0 → SETUP; else decrement and → SHIFT_LO.
  - Exactly ADDR_W rising edges per command; avr_clk returns low on leaving SHIFT_HI.
- SETUP (1 cycle):
  - avr_ce=0.
  - On a write, avr_data_oe=1 and avr_data_out=wdata.
  - avr_oe and avr_we stay 1.
- ACCESS (ACCESS_CYC cycles):
  - Read: avr_oe=0. rsp_rdata captures avr_data_in on the last ACCESS cycle.
  - Write: avr_we=0, data driven.
- HOLD (1 cycle):
  - oe/we=1; ce stays 0.
  - Write data stays driven during HOLD; avr_data_oe=0 on exit.
- DONE (1 cycle): avr_ce=1, rsp_valid=1 → IDLE.
- Exclusivity invariants:
  - avr_oe=0 and avr_we=0 never coincide.
  - avr_data_oe=1 never while avr_oe=0.
  - avr_clk never toggles while avr_ce=0.
- Latency, read or write, no skip: accept → rsp_valid = 2*HALF_DIV*ADDR_W + ACCESS_CYC + 3 cycles.
  - Defaults: 84 + 3 + 3 = 90.
- cmd_* inputs are ignored outside IDLE.
- Back-to-back commands: the next accept can occur the cycle after DONE.

Optional Feature:
- Macro: SRAM_SERIAL_ADDR_SKIP_EN.
- Defined:
  - Keep a last_addr register plus a last_valid flag; both cleared by reset.
  - On accept with last_valid=1 and cmd_addr==last_addr, go IDLE → SETUP directly, with no avr_clk edges.
  - Latency is then ACCESS_CYC + 3.
  - last_addr updates at the end of every completed shift phase.
  - An aborted shift (reset) clears last_valid.
- Undefined: every command shifts the full address; no last_addr storage.

Test Plan:
- Reset held 3 cycles during SHIFT_HI → next cycle: avr_clk=0, ce/oe/we=1, data_oe=0, cmd_ready=1, no rsp_valid.
- Read addr 0x1ABCDE, bus model returns 0x5A → 21 avr_clk rising edges, with sampled si sequence = 1_1010_1011_1100_1101_1110 (MSB first); oe low exactly 3 cycles; rsp_rdata=0x5A; rsp_valid at cycle 90 after accept.
- Write addr 0x000001 data 0xC3 → we low 3 cycles; avr_data_out=0xC3 with data_oe=1 from SETUP through HOLD; oe never low; rsp_valid pulses once.
- Back-to-back read 0x100000 then write 0x0FFFFF, with cmd_valid held → second accept the cycle after the first DONE; shifted patterns match each address; checker asserts all invariants throughout.
- cmd_valid toggled with garbage addr during ACCESS → ignored; completed transaction uses the original latched address/data.
- With SRAM_SERIAL_ADDR_SKIP_EN: two reads of 0x012345 → first shifts 21 bits (90 cycles); second has zero avr_clk edges and rsp_valid after 6 cycles. Repeat after reset → full shift again.

Source files
------------

// File: rtl/sram_serial_master_if.sv
// sram_serial_master_if: command/response and SRAM bus signals of the
// serial SRAM master, bundled so bench and design share one definition.
//
// Handshake rule: a command transfers on a rising clk edge where both
// cmd_valid and cmd_ready are high. The initiator holds cmd_we, cmd_addr
// and cmd_wdata stable while cmd_valid is high. rsp_valid is a one-cycle
// pulse with no back-pressure.
interface sram_serial_master_if #(
    parameter int ADDR_W = 21
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              avr_si;
    logic              avr_clk;
    logic              avr_ce;
    logic              avr_oe;
    logic              avr_we;
    logic [7:0]        avr_data_out;
    logic              avr_data_oe;
    logic [7:0]        avr_data_in;

    // Design-side view: accepts commands and drives the SRAM bus.
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, avr_data_in,
        output cmd_ready, rsp_valid, rsp_rdata,
        output avr_si, avr_clk, avr_ce, avr_oe, avr_we,
        output avr_data_out, avr_data_oe
    );

    // Host/bus-model view: issues commands and answers SRAM reads.
    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, avr_data_in,
        input  cmd_ready, rsp_valid, rsp_rdata,
        input  avr_si, avr_clk, avr_ce, avr_oe, avr_we,
        input  avr_data_out, avr_data_oe
    );
endinterface

// File: rtl/sram_serial_master.sv
// sram_serial_master: shifts a 21-bit SRAM address MSB first into the CPLD
// address register (avr_si/avr_clk), then performs one strobed byte read or
// write using avr_ce/avr_oe/avr_we on the shared data bus.
// Optional macro SRAM_SERIAL_ADDR_SKIP_EN: skip the shift when the new
// address equals the one already loaded in the CPLD register.
module sram_serial_master #(
    parameter int ADDR_W     = 21,
    parameter int HALF_DIV   = 2,
    parameter int ACCESS_CYC = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_serial_master_if.master bus,
    output logic [2:0]           fsm_state
);
    localparam int MAX_CYC = (HALF_DIV > ACCESS_CYC) ? HALF_DIV : ACCESS_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int BIT_W   = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACCESS_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(ADDR_W - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        SETUP    = 3'd3,
        ACCESS   = 3'd4,
        HOLD     = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rdata_q;

    logic              accept;
    logic              counting;
    logic              half_end;
    logic              acc_end;
    logic              shift_done;
    logic              skip_hit;

    logic              cmd_ready;
    logic              rsp_valid;
    logic              avr_si;
    logic              avr_clk;
    logic              avr_ce;
    logic              avr_oe;
    logic              avr_we;
    logic [7:0]        avr_data_out;
    logic              avr_data_oe;

    assign accept     = (state_q == IDLE) && bus.cmd_valid;
    assign counting   = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == ACCESS);
    assign half_end   = (div_cnt == HALF_LAST);
    assign acc_end    = (div_cnt == ACC_LAST);
    assign shift_done = (state_q == SHIFT_HI) && half_end && (bit_cnt == '0);

`ifdef SRAM_SERIAL_ADDR_SKIP_EN
    logic [ADDR_W-1:0] last_addr;
    logic              last_valid;

    // Track the address the CPLD register holds; only a completed shift counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else if (shift_done) begin
            last_addr  <= addr_q;
            last_valid <= 1'b1;
        end
    end

    assign skip_hit = last_valid && (bus.cmd_addr == last_addr);
`else
    assign skip_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: shift address bits, then one strobed access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = skip_hit ? SETUP : SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (half_end) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (shift_done) begin
                    state_d = SETUP;
                end else if (half_end) begin
                    state_d = SHIFT_LO;
                end
            end
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (acc_end) begin
                    state_d = HOLD;
                end
            end
            HOLD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latch, cycle divider, bit counter and read capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if ((state_d != state_q) || !counting) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (accept) begin
                addr_q  <= bus.cmd_addr;
                we_q    <= bus.cmd_we;
                wdata_q <= bus.cmd_wdata;
                bit_cnt <= BIT_LAST;
            end else if ((state_q == SHIFT_HI) && half_end && (bit_cnt != '0)) begin
                bit_cnt <= bit_cnt - 1'b1;
            end

            if ((state_q == ACCESS) && acc_end && !we_q) begin
                rdata_q <= bus.avr_data_in;
            end
        end
    end

    // Output decode: every bus strobe is a pure function of the state.
    always_comb begin
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        avr_si       = 1'b0;
        avr_clk      = 1'b0;
        avr_ce       = 1'b1;
        avr_oe       = 1'b1;
        avr_we       = 1'b1;
        avr_data_out = 8'h00;
        avr_data_oe  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            SHIFT_LO: begin
                avr_si = addr_q[bit_cnt];
            end
            SHIFT_HI: begin
                avr_si  = addr_q[bit_cnt];
                avr_clk = 1'b1;
            end
            SETUP, HOLD: begin
                avr_ce = 1'b0;
                if (we_q) begin
                    avr_data_oe  = 1'b1;
                    avr_data_out = wdata_q;
                end
            end
            ACCESS: begin
                avr_ce = 1'b0;
                if (we_q) begin
                    avr_we       = 1'b0;
                    avr_data_oe  = 1'b1;
                    avr_data_out = wdata_q;
                end else begin
                    avr_oe = 1'b0;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_rdata    = rdata_q;
    assign bus.avr_si       = avr_si;
    assign bus.avr_clk      = avr_clk;
    assign bus.avr_ce       = avr_ce;
    assign bus.avr_oe       = avr_oe;
    assign bus.avr_we       = avr_we;
    assign bus.avr_data_out = avr_data_out;
    assign bus.avr_data_oe  = avr_data_oe;
    assign fsm_state        = state_q;
endmodule

// File: tb/tb_sram_serial_master.sv
// tb_sram_serial_master: directed bench for sram_serial_master.
// A bus monitor counts avr_clk rising edges, captures the shifted address,
// counts strobe-low cycles and flags bus invariant breaks; each test task
// compares against hand-computed values.
`timescale 1ns/1ps
module tb_sram_serial_master;
    localparam int ADDR_W     = 21;
    localparam int HALF_DIV   = 2;
    localparam int ACCESS_CYC = 3;
    localparam int LAT_FULL   = 90;  // 2*2*21 + 3 + 3
`ifdef SRAM_SERIAL_ADDR_SKIP_EN
    localparam int LAT_REPEAT   = 6; // 3 + 3
    localparam int EDGES_REPEAT = 0;
`else
    localparam int LAT_REPEAT   = 90;
    localparam int EDGES_REPEAT = 21;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] fsm_state;

    always #5 clk = ~clk;

    sram_serial_master_if #(.ADDR_W(ADDR_W)) bus ();

    sram_serial_master #(
        .ADDR_W     (ADDR_W),
        .HALF_DIV   (HALF_DIV),
        .ACCESS_CYC (ACCESS_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- SRAM bus model ----------------
    logic [7:0] model_rdata = 8'h00;
    logic [7:0] cur_wdata   = 8'h00;
    assign bus.avr_data_in = bus.avr_oe ? 8'h00 : model_rdata;

    // ---------------- monitor ----------------
    int          mon_edges = 0, mon_oe = 0, mon_we = 0, mon_drv = 0;
    int          mon_drv_bad = 0, mon_rsp = 0, mon_viol = 0;
    logic [20:0] mon_cap   = '0;
    logic        prev_aclk = 1'b0;

    always @(negedge clk) begin
        if (bus.avr_clk && !prev_aclk) begin
            mon_edges++;
            mon_cap = {mon_cap[19:0], bus.avr_si};
        end
        prev_aclk = bus.avr_clk;
        if (!bus.avr_oe) mon_oe++;
        if (!bus.avr_we) mon_we++;
        if (bus.avr_data_oe) begin
            mon_drv++;
            if (bus.avr_data_out !== cur_wdata) mon_drv_bad++;
        end
        if (bus.rsp_valid) mon_rsp++;
        if ((!bus.avr_oe && !bus.avr_we) || (bus.avr_data_oe && !bus.avr_oe) ||
            (!bus.avr_ce && bus.avr_clk)) mon_viol++;
    end

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         s_edges, s_oe, s_we, s_drv, s_drv_bad, s_rsp, s_viol;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        s_edges = mon_edges; s_oe = mon_oe; s_we = mon_we; s_drv = mon_drv;
        s_drv_bad = mon_drv_bad; s_rsp = mon_rsp; s_viol = mon_viol;
    endtask

    // Issues one command and waits for rsp_valid; lat is -1 on timeout.
    // With poke set, cmd_valid toggles with garbage fields while in ACCESS.
    task automatic run_cmd(input logic we, input logic [20:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input bit poke,
                           output int lat, output logic [7:0] rsp_data);
        int guard;
        cur_wdata     = wdata;
        model_rdata   = rdata;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        guard = 0;
        while (!bus.cmd_ready && guard < 200) begin
            step();
            guard++;
        end
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_timeout got_ready=%b want=1", bus.cmd_ready);
        end
        step();
        lat = 1;
        bus.cmd_valid = 1'b0;
        while (!bus.rsp_valid && lat < 300) begin
            if (poke && fsm_state == 3'd4) begin
                bus.cmd_valid = ~bus.cmd_valid;
                bus.cmd_we    = 1'b0;
                bus.cmd_addr  = 21'h155555;
                bus.cmd_wdata = 8'hFF;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            step();
            lat++;
        end
        bus.cmd_valid = 1'b0;
        rsp_data = bus.rsp_rdata;
        if (!bus.rsp_valid) lat = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready got=%b want=1", bus.cmd_ready); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_rdata got=%h want=00", bus.rsp_rdata); end
        n_vec++; if ({bus.avr_si, bus.avr_clk} !== 2'b00) begin n_bad++; $display("FAIL rst_si_clk got=%b want=00", {bus.avr_si, bus.avr_clk}); end
        n_vec++; if ({bus.avr_ce, bus.avr_oe, bus.avr_we} !== 3'b111) begin n_bad++; $display("FAIL rst_strobes got=%b want=111", {bus.avr_ce, bus.avr_oe, bus.avr_we}); end
        n_vec++; if ({bus.avr_data_oe, bus.avr_data_out} !== 9'h000) begin n_bad++; $display("FAIL rst_data got=%h want=000", {bus.avr_data_oe, bus.avr_data_out}); end
    endtask

    task automatic test_reset_mid_shift();
        int guard;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 21'h1ABCDE; bus.cmd_wdata = 8'h00;
        step();
        bus.cmd_valid = 1'b0;
        guard = 0;
        while (fsm_state !== 3'd2 && guard < 50) begin step(); guard++; end
        n_vec++; if (bus.avr_clk !== 1'b1) begin n_bad++; $display("FAIL mid_reach_shift_hi got_clk=%b want=1", bus.avr_clk); end
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        snap();
        n_vec++; if (bus.avr_clk !== 1'b0) begin n_bad++; $display("FAIL mid_avr_clk got=%b want=0", bus.avr_clk); end
        n_vec++; if ({bus.avr_ce, bus.avr_oe, bus.avr_we} !== 3'b111) begin n_bad++; $display("FAIL mid_strobes got=%b want=111", {bus.avr_ce, bus.avr_oe, bus.avr_we}); end
        n_vec++; if (bus.avr_data_oe !== 1'b0) begin n_bad++; $display("FAIL mid_data_oe got=%b want=0", bus.avr_data_oe); end
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_cmd_ready got=%b want=1", bus.cmd_ready); end
        repeat (100) step();
        n_vec++; if (mon_rsp - s_rsp !== 0) begin n_bad++; $display("FAIL mid_no_rsp got=%0d want=0", mon_rsp - s_rsp); end
        n_vec++; if (mon_edges - s_edges !== 0) begin n_bad++; $display("FAIL mid_no_edges got=%0d want=0", mon_edges - s_edges); end
    endtask

    task automatic test_read();
        int lat; logic [7:0] rd, exp;
        snap();
        exp_q.push_back(8'h5A);
        run_cmd(1'b0, 21'h1ABCDE, 8'h00, 8'h5A, 1'b0, lat, rd);
        step();
        exp = exp_q.pop_front();
        n_vec++; if (lat !== LAT_FULL) begin n_bad++; $display("FAIL read_latency got=%0d want=%0d", lat, LAT_FULL); end
        n_vec++; if (rd !== exp) begin n_bad++; $display("FAIL read_rdata got=%h want=%h", rd, exp); end
        n_vec++; if (mon_edges - s_edges !== 21) begin n_bad++; $display("FAIL read_edges got=%0d want=21", mon_edges - s_edges); end
        n_vec++; if (mon_cap !== 21'h1ABCDE) begin n_bad++; $display("FAIL read_shift_addr got=%h want=1abcde", mon_cap); end
        n_vec++; if (mon_oe - s_oe !== 3) begin n_bad++; $display("FAIL read_oe_cycles got=%0d want=3", mon_oe - s_oe); end
        n_vec++; if (mon_we - s_we !== 0) begin n_bad++; $display("FAIL read_we_cycles got=%0d want=0", mon_we - s_we); end
        n_vec++; if (mon_drv - s_drv !== 0) begin n_bad++; $display("FAIL read_drive_cycles got=%0d want=0", mon_drv - s_drv); end
        n_vec++; if (mon_rsp - s_rsp !== 1) begin n_bad++; $display("FAIL read_rsp_pulses got=%0d want=1", mon_rsp - s_rsp); end
        n_vec++; if (mon_viol - s_viol !== 0) begin n_bad++; $display("FAIL read_invariants got=%0d want=0", mon_viol - s_viol); end
    endtask

    task automatic test_write();
        int lat; logic [7:0] rd;
        snap();
        run_cmd(1'b1, 21'h000001, 8'hC3, 8'h00, 1'b0, lat, rd);
        step();
        n_vec++; if (lat !== LAT_FULL) begin n_bad++; $display("FAIL write_latency got=%0d want=%0d", lat, LAT_FULL); end
        n_vec++; if (mon_cap !== 21'h000001) begin n_bad++; $display("FAIL write_shift_addr got=%h want=000001", mon_cap); end
        n_vec++; if (mon_we - s_we !== 3) begin n_bad++; $display("FAIL write_we_cycles got=%0d want=3", mon_we - s_we); end
        n_vec++; if (mon_oe - s_oe !== 0) begin n_bad++; $display("FAIL write_oe_cycles got=%0d want=0", mon_oe - s_oe); end
        n_vec++; if (mon_drv - s_drv !== 5) begin n_bad++; $display("FAIL write_drive_cycles got=%0d want=5", mon_drv - s_drv); end
        n_vec++; if (mon_drv_bad - s_drv_bad !== 0) begin n_bad++; $display("FAIL write_data_value got=%0d bad want=0", mon_drv_bad - s_drv_bad); end
        n_vec++; if (mon_rsp - s_rsp !== 1) begin n_bad++; $display("FAIL write_rsp_pulses got=%0d want=1", mon_rsp - s_rsp); end
        n_vec++; if (bus.rsp_rdata !== 8'h5A) begin n_bad++; $display("FAIL write_rdata_hold got=%h want=5a", bus.rsp_rdata); end
        n_vec++; if (mon_viol - s_viol !== 0) begin n_bad++; $display("FAIL write_invariants got=%0d want=0", mon_viol - s_viol); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] exp;
        snap();
        exp_q.push_back(8'h3C);
        model_rdata = 8'h3C;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 21'h100000; bus.cmd_wdata = 8'h00;
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ready got=%b want=1", bus.cmd_ready); end
        step();
        lat = 1;
        while (!bus.rsp_valid && lat < 300) begin step(); lat++; end
        exp = exp_q.pop_front();
        n_vec++; if (lat !== LAT_FULL) begin n_bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, LAT_FULL); end
        n_vec++; if (bus.rsp_rdata !== exp) begin n_bad++; $display("FAIL b2b_first_rdata got=%h want=%h", bus.rsp_rdata, exp); end
        n_vec++; if (mon_cap !== 21'h100000) begin n_bad++; $display("FAIL b2b_first_addr got=%h want=100000", mon_cap); end
        bus.cmd_we = 1'b1; bus.cmd_addr = 21'h0FFFFF; bus.cmd_wdata = 8'hA7;
        cur_wdata = 8'hA7;
        step();
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_second_ready got=%b want=1", bus.cmd_ready); end
        step();
        n_vec++; if (fsm_state !== 3'd1) begin n_bad++; $display("FAIL b2b_second_accept got_state=%0d want=1", fsm_state); end
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 300) begin step(); lat++; end
        step();
        n_vec++; if (lat !== LAT_FULL) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=%0d", lat, LAT_FULL); end
        n_vec++; if (mon_cap !== 21'h0FFFFF) begin n_bad++; $display("FAIL b2b_second_addr got=%h want=0fffff", mon_cap); end
        n_vec++; if (mon_edges - s_edges !== 42) begin n_bad++; $display("FAIL b2b_edges got=%0d want=42", mon_edges - s_edges); end
        n_vec++; if (mon_drv_bad - s_drv_bad !== 0 || mon_drv - s_drv !== 5) begin n_bad++; $display("FAIL b2b_write_drive got=%0d/%0d want=5/0", mon_drv - s_drv, mon_drv_bad - s_drv_bad); end
        n_vec++; if (mon_rsp - s_rsp !== 2) begin n_bad++; $display("FAIL b2b_rsp_pulses got=%0d want=2", mon_rsp - s_rsp); end
        n_vec++; if (mon_viol - s_viol !== 0) begin n_bad++; $display("FAIL b2b_invariants got=%0d want=0", mon_viol - s_viol); end
    endtask

    task automatic test_ignore_busy();
        int lat; logic [7:0] rd;
        snap();
        run_cmd(1'b1, 21'h0A5A5A, 8'h96, 8'h00, 1'b1, lat, rd);
        repeat (5) step();
        n_vec++; if (lat !== LAT_FULL) begin n_bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT_FULL); end
        n_vec++; if (mon_cap !== 21'h0A5A5A) begin n_bad++; $display("FAIL ignore_addr got=%h want=0a5a5a", mon_cap); end
        n_vec++; if (mon_we - s_we !== 3 || mon_oe - s_oe !== 0) begin n_bad++; $display("FAIL ignore_strobes got_we=%0d got_oe=%0d want=3/0", mon_we - s_we, mon_oe - s_oe); end
        n_vec++; if (mon_drv - s_drv !== 5 || mon_drv_bad - s_drv_bad !== 0) begin n_bad++; $display("FAIL ignore_wdata got=%0d/%0d want=5/0", mon_drv - s_drv, mon_drv_bad - s_drv_bad); end
        n_vec++; if (mon_rsp - s_rsp !== 1 || mon_edges - s_edges !== 21) begin n_bad++; $display("FAIL ignore_single_cmd got_rsp=%0d got_edges=%0d want=1/21", mon_rsp - s_rsp, mon_edges - s_edges); end
    endtask

    task automatic test_addr_repeat();
        int lat; logic [7:0] rd;
        snap();
        run_cmd(1'b0, 21'h012345, 8'h00, 8'h11, 1'b0, lat, rd);
        n_vec++; if (lat !== LAT_FULL || mon_edges - s_edges !== 21) begin n_bad++; $display("FAIL repeat_first got_lat=%0d got_edges=%0d want=%0d/21", lat, mon_edges - s_edges, LAT_FULL); end
        step();
        snap();
        run_cmd(1'b0, 21'h012345, 8'h00, 8'h22, 1'b0, lat, rd);
        n_vec++; if (lat !== LAT_REPEAT) begin n_bad++; $display("FAIL repeat_second_latency got=%0d want=%0d", lat, LAT_REPEAT); end
        n_vec++; if (mon_edges - s_edges !== EDGES_REPEAT) begin n_bad++; $display("FAIL repeat_second_edges got=%0d want=%0d", mon_edges - s_edges, EDGES_REPEAT); end
        n_vec++; if (rd !== 8'h22) begin n_bad++; $display("FAIL repeat_second_rdata got=%h want=22", rd); end
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        snap();
        run_cmd(1'b0, 21'h012345, 8'h00, 8'h33, 1'b0, lat, rd);
        n_vec++; if (lat !== LAT_FULL || mon_edges - s_edges !== 21) begin n_bad++; $display("FAIL repeat_after_reset got_lat=%0d got_edges=%0d want=%0d/21", lat, mon_edges - s_edges, LAT_FULL); end
        n_vec++; if (mon_cap !== 21'h012345 || rd !== 8'h33) begin n_bad++; $display("FAIL repeat_after_reset_data got_addr=%h got_rd=%h want=012345/33", mon_cap, rd); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        test_reset();
        test_reset_mid_shift();
        test_read();
        test_write();
        test_back_to_back();
        test_ignore_busy();
        test_addr_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
